// File: rtl/line_raster_if.sv
// Line-descriptor input and pixel-output handshakes of line_raster.
// The slave modport is the rasteriser side; the master modport is the
// side that supplies lines and consumes pixels.
interface line_raster_if #(
  parameter int unsigned LINE_BITS = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*LINE_BITS-1:0] in_line;
  logic                   in_thick;
  logic                   out_valid;
  logic                   out_ready;
  logic [LINE_BITS-1:0]   out_x;
  logic [LINE_BITS-1:0]   out_y;
  logic                   out_last;

  modport slave (
    input  in_valid, in_line, in_thick, out_ready,
    output in_ready, out_valid, out_x, out_y, out_last
  );

  modport master (
    output in_valid, in_line, in_thick, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/line_raster.sv
// Bresenham line rasteriser: accepts one packed {x0,y0,x1,y1} line per
// handshake and streams every pixel on it (endpoints included) with
// valid/ready backpressure.
// Optional feature macro: LINE_RASTER_THICK_EN -- when defined, a line
// accepted with in_thick=1 emits a companion pixel after every main pixel,
// offset +1 on the minor axis (wrapping).
module line_raster #(
  parameter int unsigned LINE_BITS = 7
) (
  input  logic           clk,
  input  logic           reset,
  line_raster_if.slave   bus,
  output logic           busy
);

  localparam int unsigned ERR_W = LINE_BITS + 2;
  localparam int unsigned E2_W  = LINE_BITS + 3;
  localparam logic [LINE_BITS-1:0] ONE = LINE_BITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW
`ifdef LINE_RASTER_THICK_EN
    , THICK
`endif
  } state_t;

  state_t                       state_q, state_d;
  logic [4*LINE_BITS-1:0]       line_q, line_d;
  logic [LINE_BITS-1:0]         x_q, x_d;
  logic [LINE_BITS-1:0]         y_q, y_d;
  logic signed [ERR_W-1:0]      dx_q, dx_d;
  logic signed [ERR_W-1:0]      dy_q, dy_d;
  logic signed [ERR_W-1:0]      err_q, err_d;
  logic                         sx_neg_q, sx_neg_d;
  logic                         sy_neg_q, sy_neg_d;
  logic                         major_x_q, major_x_d;
`ifdef LINE_RASTER_THICK_EN
  logic                         thick_q, thick_d;
`else
  logic                         unused_thick;
  assign unused_thick = bus.in_thick;
`endif

  logic [LINE_BITS-1:0]         lx0, ly0, lx1, ly1;
  logic [LINE_BITS-1:0]         abs_dx, abs_dy;
  logic signed [E2_W-1:0]       e2, dx_e, dy_e;
  logic                         step_x, step_y;
  logic signed [ERR_W-1:0]      err_step;
  logic [LINE_BITS-1:0]         x_step, y_step;
  logic                         at_end;
  logic                         out_hs;

  assign lx0 = line_q[4*LINE_BITS-1 -: LINE_BITS];
  assign ly0 = line_q[3*LINE_BITS-1 -: LINE_BITS];
  assign lx1 = line_q[2*LINE_BITS-1 -: LINE_BITS];
  assign ly1 = line_q[LINE_BITS-1:0];

  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign at_end       = (x_q == lx1) && (y_q == ly1);
  assign out_hs       = bus.out_valid && bus.out_ready;

  // Bresenham step: both axis decisions use the pre-step error term
  always_comb begin
    abs_dx   = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
    abs_dy   = (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1);
    e2       = {err_q, 1'b0};
    dx_e     = {dx_q[ERR_W-1], dx_q};
    dy_e     = {dy_q[ERR_W-1], dy_q};
    step_x   = (e2 >= dy_e);
    step_y   = (e2 <= dx_e);
    err_step = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    x_step   = x_q;
    y_step   = y_q;
    if (step_x) x_step = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
    if (step_y) y_step = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
  end

  // Pixel outputs decoded from state; held while the pixel is stalled
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_x     = '0;
    bus.out_y     = '0;
    bus.out_last  = 1'b0;
    case (state_q)
      DRAW: begin
        bus.out_valid = 1'b1;
        bus.out_x     = x_q;
        bus.out_y     = y_q;
`ifdef LINE_RASTER_THICK_EN
        bus.out_last  = at_end && !thick_q;
`else
        bus.out_last  = at_end;
`endif
      end
`ifdef LINE_RASTER_THICK_EN
      THICK: begin
        bus.out_valid = 1'b1;
        bus.out_x     = major_x_q ? x_q : (x_q + ONE);
        bus.out_y     = major_x_q ? (y_q + ONE) : y_q;
        bus.out_last  = at_end;
      end
`endif
      default: ;
    endcase
  end

  // Next-state: capture, setup of Bresenham terms, pixel stepping
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    sx_neg_d  = sx_neg_q;
    sy_neg_d  = sy_neg_q;
    major_x_d = major_x_q;
`ifdef LINE_RASTER_THICK_EN
    thick_d   = thick_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          line_d  = bus.in_line;
`ifdef LINE_RASTER_THICK_EN
          thick_d = bus.in_thick;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_d       = lx0;
        y_d       = ly0;
        dx_d      = {2'b00, abs_dx};
        dy_d      = '0 - {2'b00, abs_dy};
        err_d     = {2'b00, abs_dx} - {2'b00, abs_dy};
        sx_neg_d  = (lx1 < lx0);
        sy_neg_d  = (ly1 < ly0);
        major_x_d = (abs_dx >= abs_dy);
        state_d   = DRAW;
      end
      DRAW: begin
        if (out_hs) begin
`ifdef LINE_RASTER_THICK_EN
          if (thick_q) begin
            state_d = THICK;
          end else
`endif
          if (at_end) begin
            state_d = IDLE;
          end else begin
            x_d   = x_step;
            y_d   = y_step;
            err_d = err_step;
          end
        end
      end
`ifdef LINE_RASTER_THICK_EN
      // Stepping is deferred to the companion handshake so the main pixel
      // coordinates remain available for the companion offset.
      THICK: begin
        if (out_hs) begin
          if (at_end) begin
            state_d = IDLE;
          end else begin
            x_d     = x_step;
            y_d     = y_step;
            err_d   = err_step;
            state_d = DRAW;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      line_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sx_neg_q  <= 1'b0;
      sy_neg_q  <= 1'b0;
      major_x_q <= 1'b0;
`ifdef LINE_RASTER_THICK_EN
      thick_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      err_q     <= err_d;
      sx_neg_q  <= sx_neg_d;
      sy_neg_q  <= sy_neg_d;
      major_x_q <= major_x_d;
`ifdef LINE_RASTER_THICK_EN
      thick_q   <= thick_d;
`endif
    end
  end

endmodule
